tpu_result_drain: RTL

Drain engine at the south/east edge of the N x N systolic MAC array. On `start` it snapshots every PE accumulator, pulses a clear back into the array, and streams the results out in row-major order over a valid/ready interface. Each result is saturated to the output width. The array can begin the next tile while the drain is still streaming.

---
 rtl/tpu_result_drain.sv | 89 ++++++++
 1 files changed

// File: rtl/tpu_result_drain.sv
// tpu_result_drain: snapshots the N x N accumulator array on start, clears it, and streams
// saturated results row-major over a valid/ready port.
module tpu_result_drain #(
  parameter int N = 4,
  parameter int SUM_W = 32,
  parameter int OUT_W = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N*N*SUM_W-1:0]   sums_flat,
  output logic                   busy,
  output logic                   array_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat,
  output logic [IDX_W-1:0]       out_row,
  output logic [IDX_W-1:0]       out_col,
  output logic                   out_last,
  output logic                   done
);
  localparam int K_W = (N > 1) ? $clog2(N * N) : 1;
  localparam int LAST = N * N - 1;
  localparam logic [SUM_W-1:0] MAX = {SUM_W{1'b1}} >> (SUM_W - OUT_W);
  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;
  state_t state;
  logic [N*N*SUM_W-1:0] snap;
  logic [K_W-1:0] k, nk;
  logic wrap;
  assign nk = k + K_W'(1);
  assign wrap = out_col == IDX_W'(N - 1);
  function automatic logic [OUT_W:0] sat(input logic [SUM_W-1:0] v);
    return (v > MAX) ? {1'b1, {OUT_W{1'b1}}} : {1'b0, v[OUT_W-1:0]};
  endfunction
  // Output word is loaded one step ahead so it never depends combinationally on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      snap <= '0;
      k <= '0;
      busy <= 1'b0;
      array_clr <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
      out_row <= '0;
      out_col <= '0;
      out_last <= 1'b0;
      done <= 1'b0;
    end else begin
      array_clr <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          snap <= sums_flat;
          k <= '0;
          out_row <= '0;
          out_col <= '0;
          {out_sat, out_data} <= sat(sums_flat[SUM_W-1:0]);
          out_last <= 1'(LAST == 0);
          out_valid <= 1'b1;
          busy <= 1'b1;
          array_clr <= 1'b1;
          state <= STREAM;
        end
        STREAM: if (out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            done <= 1'b1;
            state <= FIN;
          end else begin
            k <= nk;
            out_col <= wrap ? '0 : out_col + IDX_W'(1);
            out_row <= wrap ? out_row + IDX_W'(1) : out_row;
            {out_sat, out_data} <= sat(snap[nk*SUM_W +: SUM_W]);
            out_last <= nk == K_W'(LAST);
          end
        end
        FIN: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
